// File: rtl/conv_window_fetch_ctrl_if.sv
// Memory read ports and window stream shared by the conv window fetch controller,
// the dual-port image memory and the conv datapath.
interface conv_window_fetch_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int K      = 3
);
    logic              mem_load;
    logic [ADDR_W-1:0] mem_addr1;
    logic [ADDR_W-1:0] mem_addr2;
    logic [7:0]        mem_data1;
    logic [7:0]        mem_data2;
    logic [8*K*K-1:0]  win_data;
    logic              win_valid;
    logic              win_ready;
    logic [7:0]        win_row;
    logic [7:0]        win_col;

    modport master (
        output mem_load, mem_addr1, mem_addr2, win_data, win_valid, win_row, win_col,
        input  mem_data1, mem_data2, win_ready
    );

    modport slave (
        input  mem_load, mem_addr1, mem_addr2, win_data, win_valid, win_row, win_col,
        output mem_data1, mem_data2, win_ready
    );
endinterface

// File: rtl/conv_window_fetch_ctrl.sv
// Walks a KxK stride-1 window over an IMG_W x IMG_H image, fetching two pixels per
// cycle from a dual-port memory and presenting each assembled window on valid/ready.
module conv_window_fetch_ctrl #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int K      = 3,
    parameter int ADDR_W = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv_window_fetch_ctrl_if.master bus
);
    localparam int NPIX = K * K;
    localparam int NP   = (NPIX + 1) / 2;
    localparam int PW   = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [PW-1:0] LAST_PAIR = PW'(NP - 1);
    localparam logic [7:0]    LAST_COL  = 8'(IMG_W - K);
    localparam logic [7:0]    LAST_ROW  = 8'(IMG_H - K);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_PRESENT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        row_q, col_q;
    logic [ADDR_W-1:0] base_q, off1, off2;
    logic [PW-1:0]     pair_q, cap_pair_q;
    logic              cap_en_q;
    logic [8*NPIX-1:0] win_q;
    logic              fetch, handshake, more_cols, more_rows;

    function automatic logic [ADDR_W-1:0] pix_offset(input int j);
        return ADDR_W'((j / K) * IMG_W + (j % K));
    endfunction

    assign fetch     = (state_q == S_FETCH);
    assign handshake = (state_q == S_PRESENT) && bus.win_ready;
    assign more_cols = col_q < LAST_COL;
    assign more_rows = row_q < LAST_ROW;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        bus.mem_load  = 1'b0;
        bus.win_valid = 1'b0;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH: begin
                busy         = 1'b1;
                bus.mem_load = 1'b1;
                if (pair_q == LAST_PAIR) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                busy          = 1'b1;
                bus.win_valid = 1'b1;
                if (bus.win_ready) state_d = (more_cols || more_rows) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pair index -> constant pixel offsets; odd K*K repeats the last pixel on port 2.
    always_comb begin
        off1 = '0;
        off2 = '0;
        for (int i = 0; i < NP; i++) begin
            if (pair_q == PW'(i)) begin
                off1 = pix_offset(2 * i);
                off2 = (2 * i + 1 < NPIX) ? pix_offset(2 * i + 1) : pix_offset(2 * i);
            end
        end
    end

    assign bus.mem_addr1 = fetch ? base_q + off1 : '0;
    assign bus.mem_addr2 = fetch ? base_q + off2 : '0;

    // base tracks row*IMG_W + col incrementally; a row wrap from col IMG_W-K advances it by K.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q      <= '0;
            col_q      <= '0;
            base_q     <= '0;
            pair_q     <= '0;
            cap_en_q   <= 1'b0;
            cap_pair_q <= '0;
        end else begin
            cap_en_q   <= fetch;
            cap_pair_q <= pair_q;
            if (state_q == S_IDLE && start) begin
                row_q  <= '0;
                col_q  <= '0;
                base_q <= '0;
                pair_q <= '0;
            end
            if (fetch) pair_q <= (pair_q == LAST_PAIR) ? '0 : pair_q + PW'(1);
            if (handshake) begin
                if (more_cols) begin
                    col_q  <= col_q + 8'd1;
                    base_q <= base_q + ADDR_W'(1);
                end else if (more_rows) begin
                    col_q  <= '0;
                    row_q  <= row_q + 8'd1;
                    base_q <= base_q + ADDR_W'(K);
                end
            end
        end
    end

    // NOTE: the window register is a plain flop bank, not a RAM, so it resets like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else if (cap_en_q) begin
            for (int j = 0; j < NPIX; j++) begin
                if (cap_pair_q == PW'(j / 2))
                    win_q[8*j +: 8] <= (j % 2 == 0) ? bus.mem_data1 : bus.mem_data2;
            end
        end
    end

    assign bus.win_data = win_q;
    assign bus.win_row  = row_q;
    assign bus.win_col  = col_q;
endmodule

// File: doc/conv_window_fetch_ctrl.md
Name: conv_window_fetch_ctrl

Overview:
- Sequences the dual-port image memory (784 x 8-bit, 28x28 row-major, registered reads gated by a load enable) for the first convolution layer.
- Walks a KxK window across the image with stride 1 and no padding.
- Issues paired reads on both memory ports and assembles each window into a wide register.
- Presents each window to the conv datapath over a valid/ready handshake. One start pulse processes one full image.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- K, 3, window edge. The window holds K*K pixels.
- ADDR_W, 10, memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins an image pass. Sampled only in IDLE.
- mem_load  out  1  read enable to the image memory.
- mem_addr1  out  ADDR_W  port-1 read address.
- mem_addr2  out  ADDR_W  port-2 read address.
- mem_data1  in  8  port-1 read data, valid 1 cycle after mem_load.
- mem_data2  in  8  port-2 read data, valid 1 cycle after mem_load.
- win_data  out  8*K*K  window pixels. Pixel j is at bits [8j+7:8j], j = r*K + c, with j=0 the top-left pixel.
- win_valid  out  1  window available.
- win_ready  in  1  consumer accepts the window.
- win_row  out  8  output row index of the current window.
- win_col  out  8  output column index of the current window.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last window is accepted.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including win_data, win_row and win_col.
  - Row/column counters and the pair counter are 0.
- States: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE:
  - start=1 moves to FETCH, clears row/col and sets busy.
- FETCH, NP = ceil(K*K/2) cycles (5 at default), pair index p = 0..NP-1:
  - base = row*IMG_W + col, with offset(j) = (j/K)*IMG_W + (j%K).
  - mem_load=1.
  - mem_addr1 = base + offset(2p).
  - mem_addr2 = base + offset(2p+1). For odd K*K on the last pair, mem_addr2 = mem_addr1 and mem_data2 is discarded.
- Capture:
  - Data for pair p is written into win_data slots 2p and 2p+1 in the cycle after issue, i.e. FETCH cycles 1..NP-1 and the DRAIN cycle.
- DRAIN (1 cycle):
  - mem_load=0.
  - Final capture; the next state is PRESENT.
- PRESENT:
  - win_valid=1.
  - win_data, win_row and win_col are held stable until win_ready=1.
  - On the handshake cycle (win_valid & win_ready):
    - If col < IMG_W-K: col+1, go to FETCH.
    - Else if row < IMG_H-K: col=0, row+1, go to FETCH.
    - Else go to DONE.
  - win_valid drops in the next cycle.
- DONE (1 cycle):
  - done=1 and busy=0 in this cycle; the next state is IDLE.
- Latency:
  - start accepted at edge 0 → first mem_load in cycle 1.
  - win_valid first high in cycle NP+2 (7 at default).
  - Each subsequent window takes NP+1 cycles after the handshake.
- Window count per image = (IMG_W-K+1)*(IMG_H-K+1) = 676 at default.
- Address arithmetic:
  - Unsigned, in ADDR_W bits.
  - Maximum address is base_max + offset(K*K-1) = IMG_W*IMG_H-1 (783), so there is never wrap-around.
- Pixel data is passed through unmodified; its signedness is the consumer's concern.
- start while not in IDLE is ignored.
- win_ready while win_valid=0 has no effect.
- mem_load is 0 in every state except FETCH.
- Reset mid-operation aborts the pass immediately: no done pulse, and the next start restarts at row 0, col 0.

Test Plan:
- Memory holds mem[i] = i mod 256, start pulse, win_ready tied 1 → FETCH address pairs are (0,1), (2,28), (29,30), (56,57), (58,58). First window bytes j0..j8 = 0,1,2,28,29,30,56,57,58. win_valid rises in cycle 7; win_row=0, win_col=0.
- Same image, win_ready held 0 for 10 cycles after the first win_valid → win_valid stays 1 with win_data unchanged and mem_load=0. Releasing win_ready produces the second window at col=1 with bytes 1,2,3,29,30,31,57,58,59.
- Column/row wrap: the handshake at row 0, col 25 is followed by a window at row 1, col 0 with base address 28 (first pair (28,29)).
- Full pass with win_ready=1 → exactly 676 handshakes. The last window is row 25, col 25, bytes 213,214,215,241,242,243,13,14,15 (addresses 725..783 mod 256). done pulses once, busy falls, and the block returns to IDLE.
- Extra start pulses during FETCH and PRESENT → ignored, no counter change. A start during IDLE after done begins a new pass at row 0, col 0.
- rst asserted during the third FETCH cycle of window (3,4) → all outputs are 0 immediately and there is no done pulse. After release plus a start, the first window is again row 0, col 0 with the correct bytes.
